aes_round_ctrl: RTL and testbench

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_round_ctrl.sv | 132 +++++++++++++
 tb/tb_aes_round_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// AES round sequencing controller: accepts a block, steps the external round
// counter as round keys arrive, and holds the ciphertext until it is consumed.
// Optional abort/flush path is built when AES_ROUND_CTRL_ABORT_EN is defined.
module aes_round_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_in_valid,
    output logic       o_in_ready,
    input  logic       i_key_rdy,
    input  logic [3:0] i_round,
    input  logic       i_is_final,
    input  logic       i_done,
    output logic       o_advance,
    output logic       o_load_state,
    output logic       o_round_en,
    output logic       o_final_en,
    output logic       o_out_valid,
    input  logic       i_out_ready,
`ifdef AES_ROUND_CTRL_ABORT_EN
    input  logic       i_abort,
`endif
    output logic       o_busy,
    output logic       o_err
);

    // state    | meaning
    // ST_IDLE  | waiting for a block, in_ready high
    // ST_RUN   | applying rounds as round keys become ready
    // ST_OUT   | ciphertext held until consumer takes it
    // ST_FLUSH | aborted block: spin round counter back to 0
`ifdef AES_ROUND_CTRL_ABORT_EN
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_OUT, ST_FLUSH} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_OUT} state_t;
`endif

    state_t r_state;
    state_t w_state_nxt;
    logic   r_final_seen;
    logic   r_err;
    logic   w_abort;
    logic   w_final_seen;
    logic   w_err_set;

`ifdef AES_ROUND_CTRL_ABORT_EN
    assign w_abort = i_abort;
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        o_in_ready   = 1'b0;
        o_load_state = 1'b0;
        o_advance    = 1'b0;
        o_round_en   = 1'b0;
        o_out_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_in_ready = 1'b1;
                if (i_in_valid) begin
                    o_load_state = 1'b1;
                    w_state_nxt  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_done) begin
                    w_state_nxt = ST_OUT;
                end else if (w_abort) begin
`ifdef AES_ROUND_CTRL_ABORT_EN
                    w_state_nxt = ST_FLUSH;
`endif
                end else begin
                    o_advance  = i_key_rdy;
                    o_round_en = i_key_rdy;
                end
            end
            ST_OUT: begin
                o_out_valid = 1'b1;
                if (w_abort || i_out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
`ifdef AES_ROUND_CTRL_ABORT_EN
            // Counter wraps to 0 on the advance at round 14, so stop on done.
            ST_FLUSH: begin
                if (i_done) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    o_advance = 1'b1;
                end
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign o_final_en = o_round_en & (i_round == 4'd14);
    assign o_busy     = (r_state != ST_IDLE);
    assign o_err      = r_err;

    // is_final arrives in the same cycle round first reads 14, so honour it
    // before it has been registered.
    assign w_final_seen = r_final_seen | i_is_final;
    assign w_err_set    = (o_advance && (i_round == 4'd14) && !w_final_seen) ||
                          (i_done && ((r_state == ST_IDLE) || (r_state == ST_OUT)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_final_seen <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (o_load_state) begin
                r_final_seen <= 1'b0;
            end else if (i_is_final) begin
                r_final_seen <= 1'b1;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl with a behavioural round counter model
// that reacts to the controller's advance output.
module tb_aes_round_ctrl;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       key_rdy;
    logic [3:0] round;
    logic       is_final;
    logic       done;
    logic       advance;
    logic       load_state;
    logic       round_en;
    logic       final_en;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       err;
    logic       force_done;
`ifdef AES_ROUND_CTRL_ABORT_EN
    logic       abort;
`endif

    logic [3:0] m_round;
    logic       m_final;
    logic       m_done;
    logic [7:0] obs;
    int         n_checks;
    int         n_fail;

    aes_round_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_key_rdy    (key_rdy),
        .i_round      (round),
        .i_is_final   (is_final),
        .i_done       (done),
        .o_advance    (advance),
        .o_load_state (load_state),
        .o_round_en   (round_en),
        .o_final_en   (final_en),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
`ifdef AES_ROUND_CTRL_ABORT_EN
        .i_abort      (abort),
`endif
        .o_busy       (busy),
        .o_err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Round counter model: same reset, pulses one cycle after the event.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_round <= 4'd0;
            m_final <= 1'b0;
            m_done  <= 1'b0;
        end else begin
            m_final <= advance && (m_round == 4'd13);
            m_done  <= advance && (m_round == 4'd14);
            if (advance) m_round <= (m_round == 4'd14) ? 4'd0 : m_round + 4'd1;
        end
    end

    assign round    = m_round;
    assign is_final = m_final;
    assign done     = m_done | force_done;
    assign obs      = {in_ready, load_state, advance, round_en, final_en, out_valid, busy, err};

    task automatic test_reset();
        logic [7:0] exp;
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        exp = 8'b1000_0000;
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b exp=%b", obs, exp);
        end
        rst_n = 1'b1;
    endtask

    // One block, key always ready, consumer ready as soon as out_valid shows.
    task automatic test_nominal();
        logic [7:0] exp;
        for (int k = 0; k <= 18; k++) begin
            @(posedge clk); #1;
            in_valid  = (k == 0);
            key_rdy   = 1'b1;
            out_ready = (k == 17);
            #1;
            exp = {(k == 0 || k == 18), (k == 0), (k >= 1 && k <= 15), (k >= 1 && k <= 15),
                   (k == 15), (k == 17), (k >= 1 && k <= 17), 1'b0};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL nominal k=%0d got=%b exp=%b", k, obs, exp);
            end
        end
    endtask

    // key_rdy low for three cycles while round reads 5.
    task automatic test_stall();
        logic [7:0] exp;
        logic       kr;
        for (int k = 0; k <= 21; k++) begin
            @(posedge clk); #1;
            kr        = !(k >= 6 && k <= 8);
            in_valid  = (k == 0);
            key_rdy   = kr;
            out_ready = (k == 20);
            #1;
            exp = {(k == 0 || k == 21), (k == 0), (kr && k >= 1 && k <= 18), (kr && k >= 1 && k <= 18),
                   (k == 18), (k == 20), (k >= 1 && k <= 20), 1'b0};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL stall k=%0d got=%b exp=%b", k, obs, exp);
            end
            if (k >= 6 && k <= 8) begin
                n_checks++;
                if (round !== 4'd5) begin
                    n_fail++;
                    $display("FAIL stall_round k=%0d got=%0d exp=5", k, round);
                end
            end
        end
    endtask

    // Consumer holds off for 10 cycles; a new block is offered meanwhile.
    task automatic test_backpressure();
        logic [7:0] exp;
        for (int k = 0; k <= 28; k++) begin
            @(posedge clk); #1;
            in_valid  = (k == 0) || (k >= 17 && k <= 27);
            key_rdy   = 1'b1;
            out_ready = (k == 27);
            #1;
            exp = {(k == 0 || k == 28), (k == 0), (k >= 1 && k <= 15), (k >= 1 && k <= 15),
                   (k == 15), (k >= 17 && k <= 27), (k >= 1 && k <= 27), 1'b0};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL backpressure k=%0d got=%b exp=%b", k, obs, exp);
            end
        end
    endtask

    // Spurious done in IDLE latches err until reset.
    task automatic test_err_sticky();
        logic [7:0] exp;
        for (int k = 0; k <= 5; k++) begin
            @(posedge clk); #1;
            in_valid   = 1'b0;
            force_done = (k == 0);
            #1;
            exp = {1'b1, 6'b000000, (k >= 1)};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL err_sticky k=%0d got=%b exp=%b", k, obs, exp);
            end
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear got=%b exp=0", err);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Reset asserted mid-block at round 7 takes effect without a clock.
    task automatic test_reset_mid_block();
        logic [7:0] exp;
        for (int k = 0; k <= 8; k++) begin
            @(posedge clk); #1;
            in_valid = (k == 0);
            key_rdy  = 1'b1;
        end
        n_checks++;
        if (round !== 4'd7) begin
            n_fail++;
            $display("FAIL mid_block_round got=%0d exp=7", round);
        end
        rst_n = 1'b0;
        #1;
        exp = 8'b1000_0000;
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL reset_mid_block got=%b exp=%b", obs, exp);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

`ifdef AES_ROUND_CTRL_ABORT_EN
    // Abort at round 4 flushes the remaining 11 rounds without round_en.
    task automatic test_abort();
        logic [7:0] exp;
        for (int k = 0; k <= 18; k++) begin
            @(posedge clk); #1;
            in_valid  = (k == 0);
            key_rdy   = (k < 5);
            abort     = (k == 5) || (k == 10);
            out_ready = 1'b0;
            #1;
            exp = {(k == 0 || k == 18), (k == 0), ((k >= 1 && k <= 4) || (k >= 6 && k <= 16)),
                   (k >= 1 && k <= 4), 1'b0, 1'b0, (k >= 1 && k <= 17), 1'b0};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL abort k=%0d got=%b exp=%b", k, obs, exp);
            end
        end
        abort = 1'b0;
    endtask
`endif

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        key_rdy    = 1'b0;
        out_ready  = 1'b0;
        force_done = 1'b0;
`ifdef AES_ROUND_CTRL_ABORT_EN
        abort      = 1'b0;
`endif
        test_reset();
        test_nominal();
        test_stall();
        test_backpressure();
        test_nominal();
        test_reset_mid_block();
        test_nominal();
`ifdef AES_ROUND_CTRL_ABORT_EN
        test_abort();
        test_nominal();
`endif
        test_err_sticky();
        test_nominal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
